// File: rtl/csa_acc_resolver_pkg.sv
// Shared parameters for the compressor-tree resolver/accumulator back end.
// Holds the default widths and the resolved-value width rule.
package csa_acc_pkg;

    localparam int DEF_W     = 16;
    localparam int DEF_ACC_W = 32;
    localparam int RES_W     = DEF_W + 3;

    // sum + 2*carry + 4*cout of W-bit vectors never exceeds 7*(2^W-1) < 2^(W+3)
    function automatic int res_w(input int w);
        return w + 3;
    endfunction

endpackage

// File: rtl/csa_acc_resolver_if.sv
// Input beat and output result channels of csa_acc_resolver.
// Valid/ready: a transfer happens on a rising edge where both valid and ready are 1.
interface csa_acc_resolver_if #(
    parameter int W     = csa_acc_pkg::DEF_W,
    parameter int ACC_W = csa_acc_pkg::DEF_ACC_W
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_sum;
    logic [W-1:0]     in_carry;
    logic [W-1:0]     in_cout;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_sum, in_carry, in_cout, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, in_carry, in_cout, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/csa_acc_resolver_resolve.sv
// Combinational resolution of weighted (sum, carry, cout) vectors into one binary value:
// a single 3:2 row followed by a carry-propagate add.
module csa_resolve
    import csa_acc_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0]         sum,
    input  logic [W-1:0]         carry,
    input  logic [W-1:0]         cout,
    output logic [res_w(W)-1:0]  v
);
    localparam int V_W = res_w(W);

    logic [V_W-1:0] a, b, c, s, k;

    assign a = V_W'(sum);
    assign b = V_W'(carry) << 1;
    assign c = V_W'(cout) << 2;

    // Majority term lands at most at bit W+1, so nothing is shifted out
    assign s = a ^ b ^ c;
    assign k = ((a & b) | (a & c) | (b & c)) << 1;
    assign v = s + k;
endmodule

// File: rtl/csa_acc_resolver.sv
// Two-stage resolver: S1 registers the resolved beat, S2 accumulates it into the group
// sum and publishes the total on the last beat. Control state is s1_v plus out_valid.
module csa_acc_resolver
    import csa_acc_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    csa_acc_resolver_if.slave bus
);
    localparam int V_W = res_w(W);

    logic [V_W-1:0]   v;
    logic [V_W-1:0]   s1_val;
    logic             s1_v;
    logic             s1_last;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [ACC_W-1:0] out_data_q;
    logic             out_ovf_q;
    logic             out_valid_q;
    logic             adv;
    logic             move;
    logic             load;
    logic             in_ready_c;
    logic [ACC_W:0]   add;

    csa_resolve #(.W(W)) u_resolve (
        .sum   (bus.in_sum),
        .carry (bus.in_carry),
        .cout  (bus.in_cout),
        .v     (v)
    );

    // in_ready depends only on registered state and out_ready, never on in_valid
    assign adv        = !out_valid_q || bus.out_ready;
    assign move       = s1_v && adv;
    assign in_ready_c = !s1_v || adv;
    assign load       = bus.in_valid && in_ready_c;
    assign add        = {1'b0, acc} + (ACC_W + 1)'(s1_val);

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v    <= 1'b0;
            s1_val  <= '0;
            s1_last <= 1'b0;
        end else if (load) begin
            s1_v    <= 1'b1;
            s1_val  <= v;
            s1_last <= bus.in_last;
        end else if (move) begin
            s1_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            ovf         <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (move && s1_last) begin
            // A new result may overwrite one being taken this same cycle
            out_data_q  <= add[ACC_W-1:0];
            out_ovf_q   <= ovf | add[ACC_W];
            out_valid_q <= 1'b1;
            acc         <= '0;
            ovf         <= 1'b0;
        end else begin
            if (move) begin
                acc <= add[ACC_W-1:0];
                ovf <= ovf | add[ACC_W];
            end
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_csa_acc_resolver.sv
// Bench for csa_acc_resolver: a 32-bit and a 20-bit accumulator instance share one stimulus
// stream; each is scored against group sums computed with plain 64-bit arithmetic.
module tb_csa_acc_resolver;
    import csa_acc_pkg::*;

    logic clk;
    logic reset;

    csa_acc_resolver_if #(.W(16), .ACC_W(32)) bus32 ();
    csa_acc_resolver_if #(.W(16), .ACC_W(20)) bus20 ();

    csa_acc_resolver #(.W(16), .ACC_W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    csa_acc_resolver #(.W(16), .ACC_W(20)) dut20 (.clk(clk), .reset(reset), .bus(bus20));

    assign bus20.in_valid  = bus32.in_valid;
    assign bus20.in_sum    = bus32.in_sum;
    assign bus20.in_carry  = bus32.in_carry;
    assign bus20.in_cout   = bus32.in_cout;
    assign bus20.in_last   = bus32.in_last;
    assign bus20.out_ready = bus32.out_ready;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] grp   = '0;
    logic [32:0] exp32_q[$];
    logic [20:0] exp20_q[$];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Sampled on the falling edge: values seen here are the ones the next rising edge uses.
    always @(negedge clk) begin
        logic [63:0] v;
        logic [32:0] e32;
        logic [20:0] e20;
        if (reset) begin
            grp = '0;
            exp32_q.delete();
            exp20_q.delete();
        end else begin
            if (bus32.out_valid && bus32.out_ready) begin
                if (exp32_q.size() == 0) check("sb32_spurious", 1, 0);
                else begin
                    e32 = exp32_q.pop_front();
                    check("sb32", {bus32.out_ovf, bus32.out_data}, e32);
                end
            end
            if (bus20.out_valid && bus20.out_ready) begin
                if (exp20_q.size() == 0) check("sb20_spurious", 1, 0);
                else begin
                    e20 = exp20_q.pop_front();
                    check("sb20", {bus20.out_ovf, bus20.out_data}, e20);
                end
            end
            if (bus32.in_valid && bus32.in_ready) begin
                v   = 64'(bus32.in_sum) + 2 * 64'(bus32.in_carry) + 4 * 64'(bus32.in_cout);
                grp = grp + v;
                if (bus32.in_last) begin
                    exp32_q.push_back({grp >= 64'h1_0000_0000, grp[31:0]});
                    exp20_q.push_back({grp >= 64'h10_0000, grp[19:0]});
                    grp = '0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_beat(input logic [15:0] s, input logic [15:0] c, input logic [15:0] o, input logic l);
        bus32.in_sum   = s;
        bus32.in_carry = c;
        bus32.in_cout  = o;
        bus32.in_last  = l;
        bus32.in_valid = 1'b1;
    endtask

    task automatic drive_beat(input logic [15:0] s, input logic [15:0] c, input logic [15:0] o, input logic l);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        set_beat(s, c, o, l);
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus32.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bus32.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input logic [31:0] d32, input logic o32, input logic [19:0] d20, input logic o20);
        bus32.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("res32", {bus32.out_valid, bus32.out_ovf, bus32.out_data}, {1'b1, o32, d32});
        check("res20", {bus20.out_valid, bus20.out_ovf, bus20.out_data}, {1'b1, o20, d20});
    endtask

    function automatic logic [15:0] rand_vec();
        if ($urandom_range(0, 3) == 0) return 16'hFFFF;
        return 16'($urandom_range(0, 65535));
    endfunction

    task automatic run_stall();
        int acc_cnt;
        logic a;
        acc_cnt = 0;
        idle(3);
        bus32.out_ready = 1'b0;
        set_beat(rand_vec(), rand_vec(), rand_vec(), 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = bus32.in_ready;
            @(posedge clk);
            #1;
            if (a) begin
                acc_cnt++;
                set_beat(rand_vec(), rand_vec(), rand_vec(), 1'b1);
            end
        end
        check("stall_absorbed", acc_cnt, 2);
        check("stall_in_ready", bus32.in_ready, 0);
        check("stall_out_valid", bus32.out_valid, 1);
        bus32.in_valid  = 1'b0;
        bus32.out_ready = 1'b1;
        idle(5);
        check("stall_drain32", exp32_q.size(), 0);
        check("stall_drain20", exp20_q.size(), 0);
    endtask

    task automatic run_random(input int beats);
        int   sent;
        int   cyc;
        logic pending;
        logic a;
        sent    = 0;
        cyc     = 0;
        pending = 1'b0;
        while (sent < beats && cyc < 60000) begin
            bus32.out_ready = ($urandom_range(0, 3) != 0);
            if (!pending && $urandom_range(0, 3) != 0) begin
                set_beat(rand_vec(), rand_vec(), rand_vec(), $urandom_range(0, 4) == 0);
                pending = 1'b1;
            end
            @(negedge clk);
            a = pending && bus32.in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (a) begin
                sent++;
                pending        = 1'b0;
                bus32.in_valid = 1'b0;
            end
        end
        check("random_beats", sent, beats);
        bus32.out_ready = 1'b1;
        drive_beat(16'd1, 16'd0, 16'd0, 1'b1);
        idle(20);
        check("random_drain32", exp32_q.size(), 0);
        check("random_drain20", exp20_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset           = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.in_sum    = '0;
        bus32.in_carry  = '0;
        bus32.in_cout   = '0;
        bus32.in_last   = 1'b0;
        bus32.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset32", {bus32.in_ready, bus32.out_valid, bus32.out_ovf, bus32.out_data}, {3'b100, 32'd0});
        check("reset20", {bus20.in_ready, bus20.out_valid, bus20.out_ovf, bus20.out_data}, {3'b100, 20'd0});
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single beat, out_valid the cycle after acceptance
        drive_beat(16'h0001, 16'h0001, 16'h0001, 1'b1);
        check("single_latency", bus32.out_valid, 0);
        expect_result(32'd7, 1'b0, 20'd7, 1'b0);
        idle(2);

        // four all-ones beats, next group back-to-back
        for (int i = 0; i < 4; i++) drive_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, i == 3);
        drive_beat(16'h0005, 16'h0000, 16'h0000, 1'b0);
        check("b2b32", {bus32.out_valid, bus32.out_ovf, bus32.out_data}, {2'b10, 32'd1834980});
        check("b2b20", {bus20.out_valid, bus20.out_ovf, bus20.out_data}, {2'b11, 20'd786404});
        drive_beat(16'h0001, 16'h0001, 16'h0000, 1'b1);
        expect_result(32'd8, 1'b0, 20'd8, 1'b0);
        idle(2);

        // 20-bit wrap and sticky-flag clear on the next group
        for (int i = 0; i < 2; i++) drive_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, i == 1);
        expect_result(32'd917490, 1'b0, 20'd917490, 1'b0);
        for (int i = 0; i < 3; i++) drive_beat(16'hFFFF, 16'hFFFF, 16'hFFFF, i == 2);
        expect_result(32'd1376235, 1'b0, 20'd327659, 1'b1);
        drive_beat(16'h0001, 16'h0001, 16'h0001, 1'b1);
        expect_result(32'd7, 1'b0, 20'd7, 1'b0);

        run_stall();

        // reset mid-group discards the partial sum
        drive_beat(rand_vec(), rand_vec(), rand_vec(), 1'b0);
        drive_beat(rand_vec(), rand_vec(), rand_vec(), 1'b0);
        bus32.in_valid = 1'b0;
        reset          = 1'b1;
        @(negedge clk);
        check("midrst32", {bus32.in_ready, bus32.out_valid, bus32.out_ovf, bus32.out_data}, {3'b100, 32'd0});
        check("midrst20", {bus20.in_ready, bus20.out_valid, bus20.out_ovf, bus20.out_data}, {3'b100, 20'd0});
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_beat(16'h0003, 16'h0000, 16'h0000, 1'b1);
        expect_result(32'd3, 1'b0, 20'd3, 1'b0);
        idle(2);

        run_random(10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
